// File: rtl/dispense_timer_multi.sv
// Multi-channel motor on-time generator: snapshots one level per channel on start and
// holds each motor enable for min(level, LVL_MAX) * CYC_PER_STEP cycles. Optional pause via DISPENSE_TIMER_PAUSE_EN.
module dispense_timer_multi #(
  parameter int N_CH         = 3,
  parameter int LVL_W        = 5,
  parameter int LVL_MAX      = 15,
  parameter int CYC_PER_STEP = 33333,
  parameter int CNT_W        = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
`ifdef DISPENSE_TIMER_PAUSE_EN
  input  logic                    pause,
`endif
  input  logic [N_CH*LVL_W-1:0]   level,
  output logic [N_CH-1:0]         motor_on,
  output logic [N_CH-1:0]         ch_done,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [LVL_W-1:0] LVL_MAX_C = LVL_W'(LVL_MAX);
  localparam logic [CNT_W-1:0] STEP_C    = CNT_W'(CYC_PER_STEP);
  localparam logic [CNT_W-1:0] ONE_C     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [CNT_W-1:0]             tmax_q, tmax_d;
  logic [N_CH-1:0][CNT_W-1:0]   t_q, t_d;
  logic                         busy_q, busy_d;
  logic                         aborted_q, aborted_d;

  logic [N_CH-1:0][CNT_W-1:0]   t_new_s;
  logic [CNT_W-1:0]             tmax_new_s;
  logic                         pause_s;
  logic                         active_s;
  logic                         done_s;

  // Clamp first so the constant multiply never sees an out-of-range level
  function automatic logic [CNT_W-1:0] on_time(input logic [LVL_W-1:0] lvl);
    logic [LVL_W-1:0] clamped;
    if (lvl > LVL_MAX_C) begin
      clamped = LVL_MAX_C;
    end else begin
      clamped = lvl;
    end
    return CNT_W'(clamped) * STEP_C;
  endfunction

`ifdef DISPENSE_TIMER_PAUSE_EN
  assign pause_s = pause;
`else
  assign pause_s = 1'b0;
`endif

  // Per-channel on-time and longest on-time for the snapshot taken at start
  always_comb begin
    t_new_s    = '0;
    tmax_new_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      t_new_s[i] = on_time(level[i*LVL_W +: LVL_W]);
      if (t_new_s[i] > tmax_new_s) begin
        tmax_new_s = t_new_s[i];
      end else begin
        tmax_new_s = tmax_new_s;
      end
    end
  end

  // Output decodes from registered state, counter and latched on-times
  always_comb begin
    motor_on = '0;
    ch_done  = '0;
    active_s = (state_q == RUN) && !pause_s;
    for (int i = 0; i < N_CH; i++) begin
      motor_on[i] = active_s && (cnt_q < t_q[i]);
      ch_done[i]  = active_s && (cnt_q == t_q[i]);
    end
    done_s = active_s && (cnt_q == tmax_q);
  end

  // Next-state, counter and snapshot logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    t_d       = t_q;
    tmax_d    = tmax_q;
    aborted_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = RUN;
          cnt_d   = '0;
          t_d     = t_new_s;
          tmax_d  = tmax_new_s;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // A done pulse already driven this cycle takes precedence over a late abort
        if (abort) begin
          state_d   = IDLE;
          cnt_d     = '0;
          aborted_d = !done_s;
        end else if (done_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (pause_s) begin
          cnt_d = cnt_q;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == RUN);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      t_q       <= '0;
      tmax_q    <= '0;
      busy_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      t_q       <= t_d;
      tmax_q    <= tmax_d;
      busy_q    <= busy_d;
      aborted_q <= aborted_d;
    end
  end

  assign busy    = busy_q;
  assign aborted = aborted_q;
  assign done    = done_s;

endmodule

// File: tb/tb_dispense_timer_multi.sv
// Scoreboard bench for dispense_timer_multi with CYC_PER_STEP = 4: stimulus pushes per-cycle
// expectations, a negedge monitor pops and compares; cycles with no entry must be all-idle.
module tb_dispense_timer_multi;

  logic        clk = 1'b0;
  logic        rst, start, abort, pause;
  logic [14:0] level;
  logic [2:0]  motor_on, ch_done;
  logic        busy, done, aborted;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int         cyc;
    logic [2:0] mo;
    logic [2:0] cd;
    logic       busy;
    logic       done;
    logic       ab;
  } exp_t;

  exp_t q[$];

  dispense_timer_multi #(
    .N_CH(3), .LVL_W(5), .LVL_MAX(15), .CYC_PER_STEP(4), .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
`ifdef DISPENSE_TIMER_PAUSE_EN
    .pause(pause),
`endif
    .level(level),
    .motor_on(motor_on),
    .ch_done(ch_done),
    .busy(busy),
    .done(done),
    .aborted(aborted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rel(input int base, input int n);
    while (cyc < base + n) tick();
  endtask

  // Expected trace of one run: r is the cycle after the start edge, e the number of unpaused RUN cycles so far.
  task automatic expect_run(input int base, input int t0, input int t1, input int t2,
                            input int ra, input int rr, input int plo, input int phi);
    int   t[3];
    int   tmax;
    int   e;
    bit   paused;
    exp_t x;
    t[0] = t0; t[1] = t1; t[2] = t2;
    tmax = t0;
    if (t1 > tmax) tmax = t1;
    if (t2 > tmax) tmax = t2;
    e = 0;
    for (int r = 1; r < 500; r++) begin
      if (rr >= 0 && r > rr) break;
      paused = (r >= plo) && (r <= phi);
      x.cyc  = base + r;
      x.busy = 1'b1;
      x.ab   = 1'b0;
      for (int i = 0; i < 3; i++) begin
        x.mo[i] = !paused && (e < t[i]);
        x.cd[i] = !paused && (e == t[i]);
      end
      x.done = !paused && (e == tmax);
      q.push_back(x);
      if (r == ra) begin
        if (!x.done) begin
          x.cyc  = base + r + 1;
          x.mo   = 3'b000;
          x.cd   = 3'b000;
          x.busy = 1'b0;
          x.done = 1'b0;
          x.ab   = 1'b1;
          q.push_back(x);
        end
        break;
      end
      if (x.done) break;
      if (!paused) e++;
    end
  endtask

  // Monitor: every sampled cycle is compared, against a queued entry or against idle
  always @(negedge clk) begin
    exp_t x;
    if (mon_en) begin
      x = '{cyc: cyc, mo: 3'b000, cd: 3'b000, busy: 1'b0, done: 1'b0, ab: 1'b0};
      while (q.size() > 0 && q[0].cyc < cyc) begin
        errors++;
        $display("FAIL stale_expectation cyc %0d: entry for cyc %0d never matched", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) x = q.pop_front();
      checks++;
      if (motor_on !== x.mo || ch_done !== x.cd || busy !== x.busy ||
          done !== x.done || aborted !== x.ab) begin
        errors++;
        $display("FAIL outputs cyc %0d: got mo=%b cd=%b busy=%b done=%b ab=%b, need mo=%b cd=%b busy=%b done=%b ab=%b",
                 cyc, motor_on, ch_done, busy, done, aborted, x.mo, x.cd, x.busy, x.done, x.ab);
      end
    end
  end

  initial begin
    int base;
    rst = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0; level = 15'd0;
    tick();
    mon_en = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();

    // Nominal {2,5,0}: T = 8, 20, 0
    base = cyc; level = {5'd0, 5'd5, 5'd2}; start = 1'b1;
    expect_run(base, 8, 20, 0, -1, -1, -1, -1);
    tick(); start = 1'b0;
    wait_rel(base, 25);

    // Clamp: 16 and 31 both become 15 -> 60 cycles
    base = cyc; level = {5'd0, 5'd31, 5'd16}; start = 1'b1;
    expect_run(base, 60, 60, 0, -1, -1, -1, -1);
    tick(); start = 1'b0;
    wait_rel(base, 65);

    // start and new levels during RUN are ignored
    base = cyc; level = {5'd0, 5'd5, 5'd2}; start = 1'b1;
    expect_run(base, 8, 20, 0, -1, -1, -1, -1);
    tick(); start = 1'b0;
    wait_rel(base, 4);
    start = 1'b1; level = {5'd9, 5'd9, 5'd9};
    tick(); start = 1'b0;
    wait_rel(base, 28);

    // Abort at cycle 5, restart at cycle 8
    base = cyc; level = {5'd0, 5'd5, 5'd2}; start = 1'b1;
    expect_run(base, 8, 20, 0, 5, -1, -1, -1);
    tick(); start = 1'b0;
    wait_rel(base, 5);
    abort = 1'b1;
    tick(); abort = 1'b0;
    wait_rel(base, 8);
    expect_run(base + 8, 8, 20, 0, -1, -1, -1, -1);
    start = 1'b1;
    tick(); start = 1'b0;
    wait_rel(base, 35);

    // abort with start in IDLE: nothing runs, no aborted pulse
    start = 1'b1; abort = 1'b1;
    tick(); start = 1'b0; abort = 1'b0;
    tick(); tick(); tick();

    // Reset mid-run at cycle 10, then a fresh run
    base = cyc; start = 1'b1;
    expect_run(base, 8, 20, 0, -1, 10, -1, -1);
    tick(); start = 1'b0;
    wait_rel(base, 10);
    rst = 1'b1;
    tick(); rst = 1'b0;
    wait_rel(base, 13);
    base = cyc; start = 1'b1;
    expect_run(base, 8, 20, 0, -1, -1, -1, -1);
    tick(); start = 1'b0;
    wait_rel(base, 25);

    // All-zero levels: single RUN cycle with every ch_done and done
    base = cyc; level = 15'd0; start = 1'b1;
    expect_run(base, 0, 0, 0, -1, -1, -1, -1);
    tick(); start = 1'b0;
    wait_rel(base, 4);

    // Abort coincident with done: done stands, no aborted pulse
    base = cyc; level = {5'd0, 5'd5, 5'd2}; start = 1'b1;
    expect_run(base, 8, 20, 0, 21, -1, -1, -1);
    tick(); start = 1'b0;
    wait_rel(base, 21);
    abort = 1'b1;
    tick(); abort = 1'b0;
    wait_rel(base, 25);

`ifdef DISPENSE_TIMER_PAUSE_EN
    // Pause during cycles 3..5 stretches the run by three cycles
    base = cyc; level = {5'd0, 5'd5, 5'd2}; start = 1'b1;
    expect_run(base, 8, 20, 0, -1, -1, 3, 5);
    tick(); start = 1'b0;
    wait_rel(base, 3);
    pause = 1'b1;
    tick(); tick(); tick();
    pause = 1'b0;
    wait_rel(base, 28);
`endif

    tick(); tick();
    mon_en = 1'b0;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drained: %0d entries left, need 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dispense_timer_multi.md
Name: dispense_timer_multi

Overview:
- Parametrised multi-channel motor on-time generator for the colour dispenser.
- Sits between the level-entry logic and the motor drivers.
- On a start pulse it snapshots one level per channel and holds each channel's motor enable for level × CYC_PER_STEP clock cycles.
- It reports per-channel and global completion, and supports abort.
- Generalises the fixed 3-channel, 5-bit timer to N_CH channels, with clamping, busy/done handshake and abort.

Parameters:
- N_CH, 3, number of motor channels.
- LVL_W, 5, bit width of each channel level.
- LVL_MAX, 15, maximum effective level; larger inputs are clamped to this value.
- CYC_PER_STEP, 33333, clock cycles of motor on-time per level unit.
- CNT_W, 32, run-counter width; must satisfy 2^CNT_W > LVL_MAX*CYC_PER_STEP.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin a dispense run; sampled only in IDLE.
- abort  in  1  terminate the current run.
- level  in  N_CH*LVL_W  channel levels; channel i is level[i*LVL_W +: LVL_W].
- motor_on  out  N_CH  per-channel motor enable.
- ch_done  out  N_CH  one-cycle pulse when a channel's on-time completes.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse when all channels have completed.
- aborted  out  1  one-cycle pulse after an abort is accepted.
- pause  in  1  present only with PAUSE_EN (see Optional Feature).

Behaviour:
- Reset:
  - rst high at an edge forces IDLE, counter = 0, and motor_on, ch_done, busy, done, aborted = 0 the next cycle.
  - Applies mid-run; no done or aborted pulse is generated.
- States: IDLE, RUN.
- IDLE → RUN:
  - Condition: start = 1 and abort = 0 sampled at edge k.
  - At edge k, latch T_i = min(level_i, LVL_MAX) * CYC_PER_STEP for every channel, and Tmax = max T_i.
  - Clear counter cnt to 0.
- RUN timing:
  - cnt increments by 1 every RUN cycle; the first RUN cycle is k+1 with cnt = 0.
  - motor_on[i] = RUN && cnt < T_i, so it is high for exactly T_i cycles, k+1 .. k+T_i.
  - ch_done[i] pulses in the cycle where cnt == T_i, i.e. cycle k+1+T_i.
  - A level-0 channel never enables its motor; its ch_done pulses in cycle k+1.
  - When cnt == Tmax: done = 1 that cycle, and the next state is IDLE.
  - busy is high in cycles k+1 .. k+1+Tmax inclusive.
  - All-zero levels: a single RUN cycle in which every ch_done and done pulse together.
- Inputs during RUN:
  - level changes have no effect (snapshot only).
  - start is ignored.
- Abort:
  - abort = 1 at an edge in RUN → next cycle IDLE, motor_on = 0, busy = 0, aborted = 1 for one cycle.
  - No further ch_done or done pulses for that run.
  - abort together with start in IDLE: abort wins; start is dropped; no aborted pulse (nothing was running).
  - abort in the same cycle as cnt == Tmax: the done pulse for that cycle has already been driven; aborted is not asserted.
- Arithmetic:
  - Clamping is done before the multiply.
  - Products are computed at CNT_W width.
  - The multiply may be pipelined one cycle only if the first motor_on cycle stays at k+1; implementers should prefer a precomputed constant multiply.
- Outputs:
  - motor_on, ch_done and done may be combinational decodes of the registered state, cnt and T_i.
  - busy and aborted are registered.

Optional Feature:
- Macro: DISPENSE_TIMER_PAUSE_EN.
- Defined:
  - The pause input port exists.
  - While pause = 1 in RUN: cnt holds, motor_on = 0 for all channels, no ch_done or done pulses, busy stays 1.
  - On release, timing resumes from the held cnt, so total motor_on cycles still equal T_i.
  - abort during pause behaves as the normal abort.
- Undefined:
  - No pause port exists; behaviour is exactly as above.

Test Plan:
- All tests use CYC_PER_STEP = 4, N_CH = 3, LVL_W = 5, LVL_MAX = 15.
- Nominal run: levels {2, 5, 0}, start at cycle 0 → motor_on[0] high cycles 1–8 and motor_on[1] high cycles 1–20; motor_on[2] never high; ch_done[2] at cycle 1, ch_done[0] at cycle 9, ch_done[1] at cycle 21; done at cycle 21; busy high cycles 1–21.
- Clamp: level 16 on channel 0 and 31 on channel 1 → each motor_on high for 60 cycles; done at cycle 61.
- Ignored inputs: start pulsed and levels changed to {9, 9, 9} at cycle 4 of the nominal run → timing identical to the nominal run; no second run begins.
- Abort: abort at cycle 5 of the nominal run → motor_on = 0 and aborted = 1 at cycle 6; busy = 0 from cycle 6; no ch_done[0], ch_done[1] or done; a new start at cycle 8 runs normally.
- Reset mid-run: rst at cycle 10 → all outputs 0 at cycle 11; no done or aborted pulse; next start behaves as from power-up.
- PAUSE_EN: nominal run with pause high for cycles 3–5 → motor_on[0] high cycles 1–2 and 6–11; ch_done[0] at cycle 12; done at cycle 24.
